// File: rtl/yc_noc_link_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : yc_noc_link_pipe
// Brief   : Elastic multi-channel NoC link, STAGES skid slices per channel.
//           Optional per-channel perf counters under macro YC_LINK_PERF_EN.
// Rev     : 1.0  initial release
// ============================================================================
module yc_noc_link_pipe #(
  parameter int FLIT_W   = 32,
  parameter int STAGES   = 2,
  parameter int CHANNELS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS*FLIT_W-1:0] in_flit,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [CHANNELS-1:0]        out_valid,
  output logic [CHANNELS*FLIT_W-1:0] out_flit,
  input  logic [CHANNELS-1:0]        out_ready
`ifdef YC_LINK_PERF_EN
  ,
  input  logic                       perf_clr,
  output logic [CHANNELS*32-1:0]     perf_flits,
  output logic [CHANNELS*32-1:0]     perf_stall
`endif
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    if (STAGES == 0) begin : g_wire
      assign out_valid[c]                 = in_valid[c];
      assign out_flit[c*FLIT_W +: FLIT_W] = in_flit[c*FLIT_W +: FLIT_W];
      assign in_ready[c]                  = out_ready[c];
    end else begin : g_pipe
      // Index s is the upstream side of stage s; index STAGES faces out_*.
      logic [STAGES:0]   w_vld;
      logic [STAGES:0]   w_rdy;
      logic [FLIT_W-1:0] w_dat [STAGES+1];

      assign w_vld[0]      = in_valid[c];
      assign w_dat[0]      = in_flit[c*FLIT_W +: FLIT_W];
      assign w_rdy[STAGES] = out_ready[c];

      assign in_ready[c]                  = w_rdy[0] & rst_n;
      assign out_valid[c]                 = w_vld[STAGES];
      assign out_flit[c*FLIT_W +: FLIT_W] = w_dat[STAGES];

      for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic              r_m_v;
        logic              r_s_v;
        logic [FLIT_W-1:0] r_m_d;
        logic [FLIT_W-1:0] r_s_d;
        logic              w_up_acc;
        logic              w_dn_acc;

        assign w_up_acc = w_vld[s] & ~r_s_v;
        assign w_dn_acc = r_m_v & w_rdy[s+1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_m_v <= 1'b0;
            r_s_v <= 1'b0;
            r_m_d <= '0;
            r_s_d <= '0;
          end else if (w_dn_acc) begin
            // Skid full implies up_ready was low, so no upstream accept here.
            if (r_s_v) begin
              r_m_d <= r_s_d;
              r_s_v <= 1'b0;
            end else if (w_up_acc) begin
              r_m_d <= w_dat[s];
            end else begin
              r_m_v <= 1'b0;
            end
          end else if (w_up_acc) begin
            if (!r_m_v) begin
              r_m_v <= 1'b1;
              r_m_d <= w_dat[s];
            end else begin
              r_s_v <= 1'b1;
              r_s_d <= w_dat[s];
            end
          end
        end

        assign w_rdy[s]   = ~r_s_v;
        assign w_vld[s+1] = r_m_v;
        assign w_dat[s+1] = r_m_d;
      end
    end

`ifdef YC_LINK_PERF_EN
    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;
    logic [31:0] r_flits;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_flits <= '0;
        r_stall <= '0;
      end else if (perf_clr) begin
        r_flits <= '0;
        r_stall <= '0;
      end else begin
        if (out_valid[c] && out_ready[c] && (r_flits != C_CNT_MAX))
          r_flits <= r_flits + 32'd1;
        if (out_valid[c] && !out_ready[c] && (r_stall != C_CNT_MAX))
          r_stall <= r_stall + 32'd1;
      end
    end

    assign perf_flits[c*32 +: 32] = r_flits;
    assign perf_stall[c*32 +: 32] = r_stall;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_yc_noc_link_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_yc_noc_link_pipe
// Brief   : Self-checking bench for yc_noc_link_pipe (STAGES=2 and STAGES=0).
// Rev     : 1.0  initial release
// ============================================================================
module tb_yc_noc_link_pipe;
  localparam int FW  = 16;
  localparam int CH  = 2;
  localparam int ST  = 2;
  localparam int CAP = 2 * ST;
  localparam int NF  = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [CH*FW-1:0] in_flit, out_flit;
  logic [CH-1:0]    z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [CH*FW-1:0] z_in_flit, z_out_flit;
`ifdef YC_LINK_PERF_EN
  logic             perf_clr, z_perf_clr;
  logic [CH*32-1:0] perf_flits, perf_stall, z_perf_flits, z_perf_stall;
`endif

  yc_noc_link_pipe #(.FLIT_W(FW), .STAGES(ST), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready)
`ifdef YC_LINK_PERF_EN
    , .perf_clr(perf_clr), .perf_flits(perf_flits), .perf_stall(perf_stall)
`endif
  );

  yc_noc_link_pipe #(.FLIT_W(FW), .STAGES(0), .CHANNELS(CH)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .in_valid(z_in_valid), .in_flit(z_in_flit), .in_ready(z_in_ready),
    .out_valid(z_out_valid), .out_flit(z_out_flit), .out_ready(z_out_ready)
`ifdef YC_LINK_PERF_EN
    , .perf_clr(z_perf_clr), .perf_flits(z_perf_flits), .perf_stall(z_perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel FIFO of accepted flits; the link must behave
  // as an ordered, lossless queue holding at most CAP flits per channel.
  logic [FW-1:0] sb0[$];
  logic [FW-1:0] sb1[$];
  int            rx [CH];
  logic [CH-1:0] hold_v = '0;
  logic [FW-1:0] hold_d [CH];
  logic [FW-1:0] m_di, m_do, m_exp;
  int            m_sz;

  initial begin
    for (int c = 0; c < CH; c++) rx[c] = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
      hold_v = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_di = in_flit[c*FW +: FW];
        m_do = out_flit[c*FW +: FW];
        if (hold_v[c]) begin
          chk("out_hold_valid", out_valid[c], 1'b1);
          chk("out_hold_flit", m_do, hold_d[c]);
        end
        if (out_valid[c] && out_ready[c]) begin
          m_sz = (c == 0) ? sb0.size() : sb1.size();
          if (m_sz == 0) begin
            total++;
            bad++;
            $display("FAIL sb_spurious ch%0d: got flit %0h expected no flit", c, m_do);
          end else begin
            if (c == 0) m_exp = sb0.pop_front();
            else        m_exp = sb1.pop_front();
            chk("sb_order", m_do, m_exp);
            rx[c]++;
          end
        end
        if (in_valid[c] && in_ready[c]) begin
          if (c == 0) sb0.push_back(m_di);
          else        sb1.push_back(m_di);
        end
        m_sz = (c == 0) ? sb0.size() : sb1.size();
        chk("capacity", m_sz <= CAP, 1'b1);
        hold_v[c] = out_valid[c] & ~out_ready[c];
        hold_d[c] = m_do;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [1:0]    iv;
    logic [CH*FW-1:0] fl;
    logic [1:0]    ordy;
    logic [1:0]    e_ov;
    logic [CH*FW-1:0] e_of;
    logic [1:0]    e_ir;
  } vec_t;
  vec_t tbl [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [CH-1:0] acc;
  int            sent [CH];
  int            rx_base [CH];
  int            k, rec, cyc;
  logic          a0;

  initial begin
    tbl[0] = '{2'b00, 32'h0000_0000, 2'b00, 2'b00, 32'h0000_0000, 2'b00};
    tbl[1] = '{2'b01, 32'h0000_1234, 2'b00, 2'b01, 32'h0000_1234, 2'b00};
    tbl[2] = '{2'b10, 32'hABCD_0000, 2'b11, 2'b10, 32'hABCD_0000, 2'b11};
    tbl[3] = '{2'b11, 32'hFFFF_FFFF, 2'b01, 2'b11, 32'hFFFF_FFFF, 2'b01};
    tbl[4] = '{2'b00, 32'h5A5A_A5A5, 2'b10, 2'b00, 32'h5A5A_A5A5, 2'b10};
    tbl[5] = '{2'b11, 32'h8001_7FFE, 2'b11, 2'b11, 32'h8001_7FFE, 2'b11};

    in_valid = '0; in_flit = '0; out_ready = '0;
    z_in_valid = '0; z_in_flit = '0; z_out_ready = '0;
`ifdef YC_LINK_PERF_EN
    perf_clr = 1'b0; z_perf_clr = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    in_valid = 2'b11;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_out_flit", out_flit, '0);
    chk("rst_in_ready", in_ready, 2'b00);
`ifdef YC_LINK_PERF_EN
    chk("rst_perf", {perf_flits, perf_stall}, '0);
`endif
    in_valid = '0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 2'b11);
    chk("rel_out_valid", out_valid, 2'b00);
    tick();

    // T4: zero-stage instance is pure wiring
    for (int i = 0; i < 6; i++) begin
      z_in_valid = tbl[i].iv; z_in_flit = tbl[i].fl; z_out_ready = tbl[i].ordy;
      #1;
      chk("t4_out_valid", z_out_valid, tbl[i].e_ov);
      chk("t4_out_flit", z_out_flit, tbl[i].e_of);
      chk("t4_in_ready", z_in_ready, tbl[i].e_ir);
    end
    for (int i = 0; i < 20; i++) begin
      z_in_valid = 2'($urandom); z_in_flit = 32'($urandom); z_out_ready = 2'($urandom);
      @(negedge clk);
      chk("t4_rand", {z_out_valid, z_out_flit, z_in_ready}, {z_in_valid, z_in_flit, z_out_ready});
      tick();
    end
    z_in_valid = '0; z_out_ready = '0;

    // T1: 16 back-to-back flits on ch0, all ready
    out_ready = 2'b11;
    for (int j = 0; j < 20; j++) begin
      if (j < 16) begin in_valid[0] = 1'b1; in_flit[FW-1:0] = 16'(j); end
      else in_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_out_valid", out_valid[0], (j >= 2 && j < 18));
      if (j >= 2 && j < 18) chk("t1_out_flit", out_flit[FW-1:0], 16'(j - 2));
      if (j < 16) chk("t1_in_ready", in_ready[0], 1'b1);
      chk("t1_ch1_idle", out_valid[1], 1'b0);
      tick();
    end

    // T2: capacity with ch0 stalled, then drain and resume
    out_ready = 2'b10;
    k = 0;
    for (int j = 0; j < 8; j++) begin
      in_valid[0] = 1'b1; in_flit[FW-1:0] = 16'(16'h0100 + k);
      @(negedge clk); a0 = in_ready[0];
      tick(); if (a0) k++;
    end
    chk("t2_accepts", k, 4);
    in_flit[FW-1:0] = 16'(16'h0100 + k);
    @(negedge clk);
    chk("t2_in_ready_low", in_ready[0], 1'b0);
    tick();
    out_ready[0] = 1'b1;
    rec = -1;
    for (int j = 0; j < 12; j++) begin
      in_valid[0] = 1'b1; in_flit[FW-1:0] = 16'(16'h0100 + k);
      @(negedge clk); a0 = in_ready[0];
      chk("t2_drain_valid", out_valid[0], 1'b1);
      chk("t2_drain_flit", out_flit[FW-1:0], 16'(16'h0100 + j));
      if (a0 && rec < 0) rec = j;
      tick(); if (a0) k++;
    end
    chk("t2_ready_recovery", (rec >= 0 && rec <= ST), 1'b1);
    in_valid[0] = 1'b0;
    repeat (6) tick();

    // T5: reset with 3 flits in flight on ch1
    out_ready = 2'b01;
    for (int j = 0; j < 3; j++) begin
      in_valid[1] = 1'b1; in_flit[FW +: FW] = 16'(16'h8200 + j);
      tick();
    end
    in_valid[1] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", out_valid, 2'b00);
    chk("t5_rst_in_ready", in_ready, 2'b00);
    chk("t5_rst_out_flit", out_flit, '0);
    tick();
    rst_n = 1'b1;
    out_ready = 2'b11;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t5_post_out_valid", out_valid, 2'b00);
      chk("t5_post_in_ready", in_ready, 2'b11);
      tick();
    end
    in_valid[1] = 1'b1; in_flit[FW +: FW] = 16'h8300;
    tick();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_new_not_yet", out_valid[1], 1'b0);
    tick();
    @(negedge clk);
    chk("t5_new_valid", out_valid[1], 1'b1);
    chk("t5_new_flit", out_flit[FW +: FW], 16'h8300);
    repeat (3) tick();

`ifdef YC_LINK_PERF_EN
    // T6: 10 delivered flits, 7 stall cycles on ch0
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr0", {perf_flits, perf_stall}, '0);
    tick();
    out_ready = 2'b10;
    for (int j = 0; j < 9; j++) begin
      in_valid[0] = (j < 4); in_flit[FW-1:0] = 16'(16'h0600 + j);
      tick();
    end
    out_ready[0] = 1'b1;
    k = 4;
    for (int j = 0; j < 30 && k < 10; j++) begin
      in_valid[0] = 1'b1; in_flit[FW-1:0] = 16'(16'h0600 + k);
      @(negedge clk); a0 = in_ready[0];
      tick(); if (a0) k++;
    end
    in_valid[0] = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("t6_flits0", perf_flits[31:0], 32'd10);
    chk("t6_stall0", perf_stall[31:0], 32'd7);
    chk("t6_flits1", perf_flits[63:32], 32'd0);
    chk("t6_stall1", perf_stall[63:32], 32'd0);
    tick();
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr_flits0", perf_flits[31:0], 32'd0);
    chk("t6_clr_stall0", perf_stall[31:0], 32'd0);
    tick();
`endif

    // T3: random traffic on both channels against the scoreboard
    for (int c = 0; c < CH; c++) begin sent[c] = 0; rx_base[c] = rx[c]; end
    in_valid = '0;
    cyc = 0;
    while ((sent[0] < NF || sent[1] < NF) && cyc < 80000) begin
      for (int c = 0; c < CH; c++) begin
        out_ready[c] = ($urandom_range(1, 100) <= 30);
        if (!in_valid[c] && sent[c] < NF && $urandom_range(1, 100) <= 50) begin
          in_valid[c] = 1'b1;
          in_flit[c*FW +: FW] = {1'(c), sent[c][14:0]};
        end
      end
      @(negedge clk); acc = in_valid & in_ready;
      tick();
      for (int c = 0; c < CH; c++) begin
        if (acc[c]) begin in_valid[c] = 1'b0; sent[c]++; end
      end
      cyc++;
    end
    chk("t3_cycle_budget", cyc < 80000, 1'b1);
    in_valid = '0;
    out_ready = 2'b11;
    repeat (2 * CAP + 2) tick();
    for (int c = 0; c < CH; c++) chk("t3_delivered", rx[c] - rx_base[c], NF);
    chk("t3_sb0_empty", sb0.size(), 0);
    chk("t3_sb1_empty", sb1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
